// File: rtl/nescart_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : nescart_mapper
//  Description : NES cartridge with PRG/CHR held in synchronous block RAM and
//                iNES-selected mapper logic: mapper 0 (NROM) and mapper 1
//                (MMC1 serial-loaded bank switching). A dedicated load port
//                fills the ROM images independently of mapper state.
//                Optional feature macro: NESCART_CHR_RAM_EN (PPU-writable CHR).
//  Revision    : 1.0 - initial release
// ============================================================================
module nescart_mapper #(
    parameter int PRG_ADDR_WIDTH = 17,
    parameter int CHR_ADDR_WIDTH = 15
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [39:0]               cfg_in,
    input  logic                      cfg_upd_in,
    input  logic                      ld_we_in,
    input  logic                      ld_sel_in,
    input  logic [PRG_ADDR_WIDTH-1:0] ld_a_in,
    input  logic [7:0]                ld_d_in,
    input  logic                      prg_nce_in,
    input  logic [14:0]               prg_a_in,
    input  logic                      prg_r_nw_in,
    input  logic [7:0]                prg_d_in,
    output logic [7:0]                prg_d_out,
    input  logic [13:0]               chr_a_in,
    input  logic                      chr_r_nw_in,
    input  logic [7:0]                chr_d_in,
    output logic [7:0]                chr_d_out,
    output logic                      ciram_nce_out,
    output logic                      ciram_a10_out
);

    localparam int          c_PRG_DEPTH  = 1 << PRG_ADDR_WIDTH;
    localparam int          c_CHR_DEPTH  = 1 << CHR_ADDR_WIDTH;
    localparam logic [4:0]  c_SHIFT_INIT = 5'b10000;
    localparam logic [4:0]  c_CTRL_INIT  = 5'h0C;

    // Mapper state
    logic [7:0]  r_mapper;
    logic [4:0]  r_shift;
    logic [4:0]  r_control;
    logic [4:0]  r_chr0;
    logic [4:0]  r_chr1;
    logic [4:0]  r_prg;
    logic        r_wr_q;

    // Memories and read registers
    logic [7:0]  r_prg_mem [0:c_PRG_DEPTH-1];
    logic [7:0]  r_chr_mem [0:c_CHR_DEPTH-1];
    logic [7:0]  r_prg_q;
    logic [7:0]  r_chr_q;

    // Combinational mapping
    logic        w_is_mmc1;
    logic        w_cpu_wr;
    logic        w_wr_event;
    logic [4:0]  w_shift_next;
    logic [7:0]  w_last_bank;
    logic        w_prg_big;
    logic [7:0]  w_prg_bank;
    logic [4:0]  w_chr_bank;
    logic        w_ciram_a10;
    logic [21:0] w_prg_full;
    logic [16:0] w_chr_full;
    logic [PRG_ADDR_WIDTH-1:0] w_prg_addr;
    logic [CHR_ADDR_WIDTH-1:0] w_chr_addr;
    logic        w_unused;

    // Unknown mapper numbers fall back to NROM behaviour
    assign w_is_mmc1    = (r_mapper == 8'd1);
    assign w_cpu_wr     = ~prg_nce_in & ~prg_r_nw_in;
    // One event per strobe: only the first cycle of a held strobe counts
    assign w_wr_event   = w_cpu_wr & ~r_wr_q & w_is_mmc1;
    assign w_shift_next = {prg_d_in[0], r_shift[4:1]};
    assign w_last_bank  = cfg_in[39:32] - 8'd1;
    assign w_prg_big    = (cfg_in[39:32] >= 8'd2);

    // MMC1 serial port, edge detector and mapper-number latch
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_mapper  <= 8'd0;
            r_shift   <= c_SHIFT_INIT;
            r_control <= c_CTRL_INIT;
            r_chr0    <= 5'd0;
            r_chr1    <= 5'd0;
            r_prg     <= 5'd0;
            r_wr_q    <= 1'b0;
        end else if (cfg_upd_in) begin
            // Header update re-initialises the mapper and swallows any write event
            r_mapper  <= {cfg_in[15:12], cfg_in[23:20]};
            r_shift   <= c_SHIFT_INIT;
            r_control <= c_CTRL_INIT;
            r_chr0    <= 5'd0;
            r_chr1    <= 5'd0;
            r_prg     <= 5'd0;
            r_wr_q    <= 1'b0;
        end else begin
            r_wr_q <= w_cpu_wr;
            if (w_wr_event) begin
                if (prg_d_in[7]) begin
                    r_shift   <= c_SHIFT_INIT;
                    r_control <= r_control | 5'h0C;
                end else if (r_shift[0]) begin
                    // Sentinel reached bit 0: this is the fifth write
                    r_shift <= c_SHIFT_INIT;
                    case (prg_a_in[14:13])
                        2'd0:    r_control <= w_shift_next;
                        2'd1:    r_chr0    <= w_shift_next;
                        2'd2:    r_chr1    <= w_shift_next;
                        default: r_prg     <= w_shift_next;
                    endcase
                end else begin
                    r_shift <= w_shift_next;
                end
            end
        end
    end

    // Bank selection and nametable mirroring for the active mapper
    always_comb begin
        w_prg_bank  = 8'd0;
        w_chr_bank  = 5'd0;
        w_ciram_a10 = chr_a_in[11];
        if (w_is_mmc1) begin
            case (r_control[3:2])
                2'd2:    w_prg_bank = prg_a_in[14] ? {4'd0, r_prg[3:0]} : 8'd0;
                2'd3:    w_prg_bank = prg_a_in[14] ? w_last_bank : {4'd0, r_prg[3:0]};
                default: w_prg_bank = {4'd0, r_prg[3:1], prg_a_in[14]};
            endcase
            if (r_control[4]) begin
                w_chr_bank = chr_a_in[12] ? r_chr1 : r_chr0;
            end else begin
                w_chr_bank = {r_chr0[4:1], chr_a_in[12]};
            end
            case (r_control[1:0])
                2'd0:    w_ciram_a10 = 1'b0;
                2'd1:    w_ciram_a10 = 1'b1;
                2'd2:    w_ciram_a10 = chr_a_in[10];
                default: w_ciram_a10 = chr_a_in[11];
            endcase
        end else begin
            // A single 16 KB PRG unit is mirrored into both halves of the window
            w_prg_bank  = {7'd0, w_prg_big & prg_a_in[14]};
            w_chr_bank  = {4'd0, chr_a_in[12]};
            w_ciram_a10 = cfg_in[16] ? chr_a_in[10] : chr_a_in[11];
        end
    end

    // Bank numbers are 16 KB (PRG) / 4 KB (CHR); upper bits wrap by truncation
    assign w_prg_full = {w_prg_bank, prg_a_in[13:0]};
    assign w_chr_full = {w_chr_bank, chr_a_in[11:0]};
    assign w_prg_addr = w_prg_full[PRG_ADDR_WIDTH-1:0];
    assign w_chr_addr = w_chr_full[CHR_ADDR_WIDTH-1:0];

    // PRG BRAM: load port first, NROM CPU writes second, registered read
    always_ff @(posedge clk_in) begin
        if (ld_we_in && !ld_sel_in) begin
            r_prg_mem[ld_a_in] <= ld_d_in;
        end else if (w_cpu_wr && !w_is_mmc1) begin
            r_prg_mem[w_prg_addr] <= prg_d_in;
        end
        r_prg_q <= r_prg_mem[w_prg_addr];
    end

    // CHR BRAM: load port always, PPU writes only when CHR is RAM
    always_ff @(posedge clk_in) begin
        if (ld_we_in && ld_sel_in) begin
            r_chr_mem[ld_a_in[CHR_ADDR_WIDTH-1:0]] <= ld_d_in;
        end
`ifdef NESCART_CHR_RAM_EN
        else if (!chr_r_nw_in && !chr_a_in[13]) begin
            r_chr_mem[w_chr_addr] <= chr_d_in;
        end
`endif
        r_chr_q <= r_chr_mem[w_chr_addr];
    end

    assign prg_d_out     = prg_nce_in   ? 8'h00 : r_prg_q;
    assign chr_d_out     = chr_a_in[13] ? 8'h00 : r_chr_q;
    assign ciram_nce_out = ~chr_a_in[13];
    assign ciram_a10_out = w_ciram_a10;

    // Header fields and address bits that no mapping path consumes
    assign w_unused = ^{cfg_in, r_prg[4], ld_a_in, w_prg_full, w_chr_full,
                        chr_d_in, chr_r_nw_in};

endmodule
`default_nettype wire

// File: doc/nescart_mapper.md
# nescart_mapper

Parametrised successor to the fixed NROM cartridge: holds PRG and CHR memory in synchronous block RAM and adds mapper logic selected from the iNES header, with mapper 0 (NROM) and mapper 1 (MMC1 serial-loaded bank switching) supported. It sits between the CPU/PPU buses and cartridge memory. A dedicated load port fills ROM images independently of mapper state.

## Interface
- PRG_ADDR_WIDTH, 17: PRG memory address bits (2^17 = 128 KB, eight 16 KB banks)
- CHR_ADDR_WIDTH, 15: CHR memory address bits (2^15 = 32 KB, eight 4 KB banks)
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- cfg_in  input  40  header: [39:32] PRG 16 KB units, [31:24] CHR 8 KB units, [23:16] flags6, [15:8] flags7, [7:0] unused
- cfg_upd_in  input  1  one-cycle pulse; latches mapper number, re-initialises mapper registers
- ld_we_in  input  1  load-port write strobe
- ld_sel_in  input  1  0 = PRG, 1 = CHR
- ld_a_in  input  PRG_ADDR_WIDTH  linear load address (CHR uses low CHR_ADDR_WIDTH bits)
- ld_d_in  input  8  load data
- prg_nce_in  input  1  PRG chip enable, active low ($8000-$FFFF)
- prg_a_in  input  15  CPU A[14:0]
- prg_r_nw_in  input  1  1 = read, 0 = write
- prg_d_in  input  8  CPU write data
- prg_d_out  output  8  PRG read data
- chr_a_in  input  14  PPU address
- chr_r_nw_in  input  1  1 = read, 0 = write
- chr_d_in  input  8  PPU write data
- chr_d_out  output  8  CHR read data
- ciram_nce_out  output  1  VRAM enable, active low
- ciram_a10_out  output  1  VRAM A10

## Operation
- Mapper number = {cfg_in[15:12], cfg_in[23:20]}, latched on cfg_upd_in. Values other than 0 or 1 behave as 0.
- Mapper 0:
  - PRG address = prg_a_in[14:0] if PRG units ≥ 2, else {0, prg_a_in[13:0]}.
  - CHR address = chr_a_in[12:0].
  - ciram_a10_out = cfg_in[16] ? chr_a_in[10] : chr_a_in[11].
  - CPU writes go to PRG BRAM.
- Mapper 1 (MMC1):
  - Write event = rising edge of (~prg_nce_in & ~prg_r_nw_in), detected against a registered copy. Exactly one event per strobe, however many cycles the strobe is held. CPU writes never reach PRG BRAM.
  - Event with d[7] = 1: shift register reset to 5'b10000; control |= 5'h0C.
  - Event with d[7] = 0: shift right, inserting d[0] at bit 4. If the sentinel bit falls out (5th write), load the assembled value into the register selected by prg_a_in[14:13]: 0 control, 1 chr0, 2 chr1, 3 prg. The shift register then returns to 5'b10000.
  - PRG mode, control[3:2]:
    - 0 or 1: 32 KB window at bank {prg[3:1], A14}.
    - 2: $8000 = bank 0; $C000 = prg[3:0].
    - 3: $8000 = prg[3:0]; $C000 = last bank, i.e. cfg_in[39:32] − 1.
  - CHR mode, control[4]:
    - 0: 8 KB at {chr0[4:1], A12}.
    - 1: A12 selects chr0 or chr1, each a 4 KB bank.
  - Mirroring, control[1:0] drives ciram_a10_out: 0 → 0, 1 → 1, 2 → chr_a_in[10], 3 → chr_a_in[11].
- All bank arithmetic is truncated to PRG_ADDR_WIDTH / CHR_ADDR_WIDTH, so out-of-range banks wrap.
- The load port writes BRAM at ld_a_in, bypassing mapping. It has priority over any same-cycle bus write to the same BRAM.
- ciram_nce_out = ~chr_a_in[13].
- chr_d_out is driven only when chr_a_in[13] = 0; otherwise 0.
- prg_d_out is driven only when prg_nce_in = 0; otherwise 0.

## Timing
- Reset values (async on rst_n_in low, also on cfg_upd_in):
  - shift = 5'b10000, control = 5'h0C, chr0 = chr1 = prg = 0, edge register = 0.
  - Mapper number = 0 on rst_n_in only.
- Outputs are combinational from enables: prg_d_out = 0 and chr_d_out = 0 while deselected.
- Read latency is 1 clk_in: the address is sampled at edge N and data is valid after edge N.
- A 5th-write register update is visible in address mapping on the cycle after the event edge.
- cfg_upd_in coinciding with a write event: cfg_upd_in wins and the event is dropped.
- Reset mid-sequence discards partial shift contents.

## Configuration
- NESCART_CHR_RAM_EN defined: PPU writes (chr_r_nw_in = 0, chr_a_in[13] = 0) write CHR BRAM at the mapped address.
- NESCART_CHR_RAM_EN undefined: CHR is ROM. PPU writes are ignored and only the load port writes CHR.

## Test plan
- Mapper 0, PRG units = 1: load $3FFF = $A5; CPU read at $7FFF → prg_d_out = $A5 one cycle later.
- Mapper 1: five writes to $E000 with d[0] = 1,0,0,0,0 (value 1), control = $0C → read $8000 returns PRG byte at $04000; $C000 returns last bank.
- Mapper 1: a single write strobe held 4 cycles, then 4 more writes → register loads after the 5th distinct strobe, not earlier.
- Mapper 1: write $80 after 3 partial writes → shift cleared, control[3:2] = 3; the next 5 writes load cleanly.
- Mapper 1: control = $13 (4 KB CHR, horizontal), chr1 = 3; PPU read $1000 → CHR $3000; ciram_a10_out follows chr_a_in[11].
- Assert rst_n_in during the 3rd MMC1 write → all registers reset immediately; cfg_upd_in concurrent with a write → write dropped.
